// File: rtl/tl_rx_pkg.sv
// Shared types and defaults for the TL RX per-VC buffers.
// Optional feature macro used by the buffer: TL_RX_VC_OVF_CHK_EN.
package tl_rx_pkg;

  typedef enum logic [1:0] {
    FC_IDLE,
    FC_WAIT,
    FC_SEND
  } fc_state_t;

  localparam int TL_RX_DEPTH      = 16;
  localparam int TL_RX_CREDIT_W   = 8;
  localparam int TL_RX_FC_THRESH  = 4;
  localparam int TL_RX_FC_TIMEOUT = 64;

endpackage

// File: rtl/tl_rx_fc_tracker.sv
// Freed-credit batching for one VC: counts pops, issues FC updates with a new credit limit.
//   state   | meaning
//   FC_IDLE | no freed credits outstanding, timer parked
//   FC_WAIT | freed credits pending; batching until threshold or timeout
//   FC_SEND | update presented on fc_valid_o/fc_limit_o, waiting for fc_ready_i
module tl_rx_fc_tracker
  import tl_rx_pkg::*;
#(
  parameter int DEPTH      = TL_RX_DEPTH,
  parameter int CREDIT_W   = TL_RX_CREDIT_W,
  parameter int FC_THRESH  = TL_RX_FC_THRESH,
  parameter int FC_TIMEOUT = TL_RX_FC_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pop,
  output logic                fc_valid_o,
  input  logic                fc_ready_i,
  output logic [CREDIT_W-1:0] fc_limit_o
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(FC_TIMEOUT + 1);

  fc_state_t             state_q;
  logic [LW-1:0]         freed_q;
  logic [LW-1:0]         captured_q;
  logic [TW-1:0]         timer_q;
  logic                  fc_valid_q;
  logic [CREDIT_W-1:0]   fc_limit_q;
  logic [LW-1:0]         freed_inc;
  logic [LW-1:0]         freed_left;

  assign freed_inc  = freed_q + {{(LW-1){1'b0}}, pop};
  assign freed_left = freed_inc - captured_q;

  // Timeout is a down-counter: reloaded to FC_TIMEOUT-1, update forced at terminal count 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FC_IDLE;
      freed_q    <= '0;
      captured_q <= '0;
      timer_q    <= TW'(FC_TIMEOUT - 1);
      fc_valid_q <= 1'b0;
      fc_limit_q <= CREDIT_W'(DEPTH);
    end else begin
      freed_q <= freed_inc;
      case (state_q)
        FC_IDLE: begin
          timer_q <= TW'(FC_TIMEOUT - 1);
          if (pop) state_q <= FC_WAIT;
        end
        FC_WAIT: begin
          if (freed_q >= LW'(FC_THRESH) || timer_q == '0) begin
            state_q    <= FC_SEND;
            fc_valid_q <= 1'b1;
            captured_q <= freed_inc;
            fc_limit_q <= fc_limit_q + CREDIT_W'(freed_inc);
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        FC_SEND: begin
          if (fc_ready_i) begin
            fc_valid_q <= 1'b0;
            freed_q    <= freed_left;
            timer_q    <= TW'(FC_TIMEOUT - 1);
            state_q    <= (freed_left != '0) ? FC_WAIT : FC_IDLE;
          end
        end
        default: state_q <= FC_IDLE;
      endcase
    end
  end

  assign fc_valid_o = fc_valid_q;
  assign fc_limit_o = fc_limit_q;

endmodule

// File: rtl/tl_rx_vc_buffer.sv
// Per-VC receive buffer: circular show-ahead store feeding the arbiter, plus FC credit return.
// Define TL_RX_VC_OVF_CHK_EN to add the sticky ovf_err_o port for writes while full.
module tl_rx_vc_buffer
  import tl_rx_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int DEPTH      = TL_RX_DEPTH,
  parameter int CREDIT_W   = TL_RX_CREDIT_W,
  parameter int FC_THRESH  = TL_RX_FC_THRESH,
  parameter int FC_TIMEOUT = TL_RX_FC_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [DATA_SIZE-1:0]     wr_data_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [DATA_SIZE-1:0]     rd_data_o,
  output logic                     fc_valid_o,
  input  logic                     fc_ready_i,
  output logic [CREDIT_W-1:0]      fc_limit_o,
  output logic [$clog2(DEPTH):0]   level_o
`ifdef TL_RX_VC_OVF_CHK_EN
  ,
  output logic                     ovf_err_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [LW-1:0]        level_q;
  logic                 push;
  logic                 pop;

  // Ready/valid come from the registered level only, so a pop at full frees the slot next cycle.
  assign wr_ready_o = (level_q != LW'(DEPTH));
  assign rd_valid_o = (level_q != '0);
  assign rd_data_o  = rd_valid_o ? mem[rd_ptr_q] : '0;
  assign level_o    = level_q;
  assign push       = wr_valid_i && wr_ready_o;
  assign pop        = rd_valid_o && rd_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data_i;
  end

`ifdef TL_RX_VC_OVF_CHK_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (rst)                            ovf_q <= 1'b0;
    else if (wr_valid_i && !wr_ready_o) ovf_q <= 1'b1;
  end
  assign ovf_err_o = ovf_q;
`endif

  tl_rx_fc_tracker #(
    .DEPTH      (DEPTH),
    .CREDIT_W   (CREDIT_W),
    .FC_THRESH  (FC_THRESH),
    .FC_TIMEOUT (FC_TIMEOUT)
  ) u_fc (
    .clk        (clk),
    .rst        (rst),
    .pop        (pop),
    .fc_valid_o (fc_valid_o),
    .fc_ready_i (fc_ready_i),
    .fc_limit_o (fc_limit_o)
  );

endmodule

// File: tb/tb_tl_rx_vc_buffer.sv
// Directed bench for tl_rx_vc_buffer: vector table plus hand sequences for full/stream/FC corners.
module tb_tl_rx_vc_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid_i = 1'b0;
  logic        wr_ready_o;
  logic [31:0] wr_data_i = '0;
  logic        rd_valid_o;
  logic        rd_ready_i = 1'b0;
  logic [31:0] rd_data_o;
  logic        fc_valid_o;
  logic        fc_ready_i = 1'b1;
  logic [7:0]  fc_limit_o;
  logic [4:0]  level_o;
`ifdef TL_RX_VC_OVF_CHK_EN
  logic        ovf_err_o;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tl_rx_vc_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .wr_data_i  (wr_data_i),
    .rd_valid_o (rd_valid_o),
    .rd_ready_i (rd_ready_i),
    .rd_data_o  (rd_data_o),
    .fc_valid_o (fc_valid_o),
    .fc_ready_i (fc_ready_i),
    .fc_limit_o (fc_limit_o),
    .level_o    (level_o)
`ifdef TL_RX_VC_OVF_CHK_EN
    ,
    .ovf_err_o  (ovf_err_o)
`endif
  );

  typedef struct {
    logic        wv;
    logic [31:0] wd;
    logic        rr;
    logic        e_rv;
    logic [31:0] e_rd;
    int          e_lvl;
    logic        e_wrdy;
    logic        e_fcv;
    int          e_fcl;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, return at the next negedge with post-edge outputs.
  task automatic cycle(input logic wv, input logic [31:0] wd, input logic rr);
    wr_valid_i = wv;
    wr_data_i  = wd;
    rd_ready_i = rr;
    @(negedge clk);
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b0;
  endtask

  task automatic wait_fc(output int n);
    n = 0;
    while (!fc_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!fc_valid_o) begin
      tests++;
      fails++;
      $display("FAIL fc_wait_timeout: got fc_valid 0 expected 1 within 200 cycles");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] q[$];
    logic [31:0] nxt;

    vecs[0]  = '{1'b1, 32'hA000_0001, 1'b0, 1'b1, 32'hA000_0001, 1, 1'b1, 1'b0, 16};
    vecs[1]  = '{1'b1, 32'hA000_0002, 1'b0, 1'b1, 32'hA000_0001, 2, 1'b1, 1'b0, 16};
    vecs[2]  = '{1'b1, 32'hA000_0003, 1'b0, 1'b1, 32'hA000_0001, 3, 1'b1, 1'b0, 16};
    vecs[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hA000_0001, 3, 1'b1, 1'b0, 16};
    vecs[4]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hA000_0002, 2, 1'b1, 1'b0, 16};
    vecs[5]  = '{1'b1, 32'hA000_0004, 1'b1, 1'b1, 32'hA000_0003, 2, 1'b1, 1'b0, 16};
    vecs[6]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hA000_0004, 1, 1'b1, 1'b0, 16};
    vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         0, 1'b1, 1'b0, 16};
    vecs[8]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         0, 1'b1, 1'b1, 20};
    vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         0, 1'b1, 1'b0, 20};
    vecs[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         0, 1'b1, 1'b0, 20};

    repeat (3) @(negedge clk);
    check("rst_wr_ready", 64'(wr_ready_o), 64'd1);
    check("rst_rd_valid", 64'(rd_valid_o), 64'd0);
    check("rst_rd_data",  64'(rd_data_o),  64'd0);
    check("rst_fc_valid", 64'(fc_valid_o), 64'd0);
    check("rst_fc_limit", 64'(fc_limit_o), 64'd16);
    check("rst_level",    64'(level_o),    64'd0);
`ifdef TL_RX_VC_OVF_CHK_EN
    check("rst_ovf", 64'(ovf_err_o), 64'd0);
`endif
    rst = 1'b0;

    // Vector table: basic pushes, show-ahead, mixed push/pop, first FC update at 20.
    for (int i = 0; i < 11; i++) begin
      wr_valid_i = vecs[i].wv;
      wr_data_i  = vecs[i].wd;
      rd_ready_i = vecs[i].rr;
      if (i == 0) begin
        #1;
        check("no_bypass_rd_valid", 64'(rd_valid_o), 64'd0);
      end
      @(negedge clk);
      wr_valid_i = 1'b0;
      rd_ready_i = 1'b0;
      check($sformatf("v%0d_rd_valid", i), 64'(rd_valid_o), 64'(vecs[i].e_rv));
      check($sformatf("v%0d_rd_data", i),  64'(rd_data_o),  64'(vecs[i].e_rd));
      check($sformatf("v%0d_level", i),    64'(level_o),    64'(vecs[i].e_lvl));
      check($sformatf("v%0d_wr_ready", i), 64'(wr_ready_o), 64'(vecs[i].e_wrdy));
      check($sformatf("v%0d_fc_valid", i), 64'(fc_valid_o), 64'(vecs[i].e_fcv));
      check($sformatf("v%0d_fc_limit", i), 64'(fc_limit_o), 64'(vecs[i].e_fcl));
    end

    // Single pop: forced update after the 64-cycle timeout, limit 21.
    cycle(1'b1, 32'hB000_0001, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    wait_fc(n);
    check("timeout_cycles", 64'(n), 64'd64);
    check("timeout_limit", 64'(fc_limit_o), 64'd21);
    @(negedge clk);
    check("timeout_fc_drop", 64'(fc_valid_o), 64'd0);

    // Fill to full, write while full, pop at full, drain in order.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 32'h100 + i, 1'b0);
      check($sformatf("fill_level_%0d", i), 64'(level_o), 64'(i + 1));
    end
    check("full_wr_ready", 64'(wr_ready_o), 64'd0);
    cycle(1'b1, 32'hDEAD_0000, 1'b0);
    check("full_write_level", 64'(level_o), 64'd16);
    check("full_write_head", 64'(rd_data_o), 64'h100);
`ifdef TL_RX_VC_OVF_CHK_EN
    check("ovf_set", 64'(ovf_err_o), 64'd1);
    @(negedge clk);
    check("ovf_sticky", 64'(ovf_err_o), 64'd1);
`endif
    wr_valid_i = 1'b1;
    wr_data_i  = 32'hBEEF_0000;
    rd_ready_i = 1'b1;
    #1;
    check("full_pop_wr_ready_same_cycle", 64'(wr_ready_o), 64'd0);
    @(negedge clk);
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    check("full_pop_level", 64'(level_o), 64'd15);
    check("full_pop_wr_ready_next", 64'(wr_ready_o), 64'd1);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("drain_data_%0d", i), 64'(rd_data_o), 64'(32'h100 + i));
      cycle(1'b0, 32'h0, 1'b1);
    end
    check("drain_empty", 64'(rd_valid_o), 64'd0);
`ifdef TL_RX_VC_OVF_CHK_EN
    check("ovf_sticky_after_drain", 64'(ovf_err_o), 64'd1);
`endif
    repeat (150) @(negedge clk);
    check("limit_after_fill", 64'(fc_limit_o), 64'd37);

    // Streaming at level 5 for 40 cycles, pointers wrap several times.
    for (int i = 0; i < 5; i++) begin
      nxt = 32'h200 + i;
      cycle(1'b1, nxt, 1'b0);
      q.push_back(nxt);
    end
    for (int i = 0; i < 40; i++) begin
      nxt = 32'h300 + i;
      cycle(1'b1, nxt, 1'b1);
      q.push_back(nxt);
      void'(q.pop_front());
      check($sformatf("stream_level_%0d", i), 64'(level_o), 64'd5);
      check($sformatf("stream_data_%0d", i), 64'(rd_data_o), 64'(q[0]));
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stream_drain_%0d", i), 64'(rd_data_o), 64'(q[0]));
      void'(q.pop_front());
      cycle(1'b0, 32'h0, 1'b1);
    end
    check("stream_empty", 64'(level_o), 64'd0);
    repeat (150) @(negedge clk);
    check("limit_after_stream", 64'(fc_limit_o), 64'd82);

    // Back-pressured FC update: payload frozen while pending, remainder sent later.
    fc_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) cycle(1'b1, 32'h400 + i, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);
    wait_fc(n);
    check("bp_first_limit", 64'(fc_limit_o), 64'd86);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      check($sformatf("bp_hold_valid_%0d", i), 64'(fc_valid_o), 64'd1);
      check($sformatf("bp_hold_limit_%0d", i), 64'(fc_limit_o), 64'd86);
    end
    fc_ready_i = 1'b1;
    @(negedge clk);
    fc_ready_i = 1'b0;
    check("bp_accept_drop", 64'(fc_valid_o), 64'd0);
    wait_fc(n);
    check("bp_second_cycles", 64'(n), 64'd64);
    check("bp_second_limit", 64'(fc_limit_o), 64'd89);
    fc_ready_i = 1'b1;
    @(negedge clk);
    check("bp_second_drop", 64'(fc_valid_o), 64'd0);

    // Reset mid-operation discards stored words and pending credits.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h500 + i, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_level", 64'(level_o), 64'd0);
    check("mid_rst_rd_valid", 64'(rd_valid_o), 64'd0);
    check("mid_rst_rd_data", 64'(rd_data_o), 64'd0);
    check("mid_rst_fc_limit", 64'(fc_limit_o), 64'd16);
`ifdef TL_RX_VC_OVF_CHK_EN
    check("mid_rst_ovf", 64'(ovf_err_o), 64'd0);
`endif
    repeat (80) @(negedge clk);
    check("mid_rst_no_update", 64'(fc_valid_o), 64'd0);
    cycle(1'b1, 32'h600, 1'b0);
    check("mid_rst_new_head", 64'(rd_data_o), 64'h600);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
